// File: rtl/core_pkg.sv
// Shared ISA constants and run-controller state encoding for the 9-bit core.
// Pure declarations: no logic, no latency, no flow control.
package core_pkg;

  localparam int ISA_W = 9;
  localparam logic [ISA_W-1:0] HALT_OP_DEFAULT = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; count visible one cycle after inc.
// No backpressure: inc is ignored once the counter sits at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run/sequencing controller: starts on req, steps the PC, inserts MEM_LAT wait states, stops on HALT or END_ADDR.
// PC updates one cycle after commit; commit is combinational; req is ignored while busy.
module core_run_ctrl
  import core_pkg::*;
#(
  parameter int             D        = 12,
  parameter int             IW       = ISA_W,
  parameter int             END_ADDR = 128,
  parameter logic [IW-1:0]  HALT_OP  = IW'(HALT_OP_DEFAULT),
  parameter int             MEM_LAT  = 1,
  parameter int             CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [D-1:0]  start_addr,
  input  logic [IW-1:0] instr,
  input  logic          is_mem,
  input  logic          branch_en,
  input  logic          branch_taken,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          commit,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_cnt,
  output logic [CW-1:0] instr_cnt
);

  localparam int             WCW      = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [D-1:0]   END_PC   = D'(END_ADDR);
  localparam logic [WCW-1:0] LAT_LOAD = WCW'(MEM_LAT);
  localparam bit             HAS_WAIT = (MEM_LAT > 0);

  run_state_t     state, state_nxt;
  logic [D-1:0]   pc_nxt, pc_adv;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic           start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  assign pc_adv = (branch_en && branch_taken) ? target : prog_ctr + D'(1);

  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    wait_nxt  = wait_cnt;
    commit    = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (req) begin
          start     = 1'b1;
          pc_nxt    = start_addr;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // End address outranks HALT, and HALT outranks a memory access.
        if (prog_ctr == END_PC) begin
          state_nxt = DONE;
        end else if (instr == HALT_OP) begin
          state_nxt = DONE;
        end else if (is_mem && HAS_WAIT) begin
          state_nxt = WAIT;
          wait_nxt  = LAT_LOAD;
        end else begin
          commit = 1'b1;
          pc_nxt = pc_adv;
        end
      end
      WAIT: begin
        wait_nxt = wait_cnt - WCW'(1);
        if (wait_cnt == WCW'(1)) begin
          commit    = 1'b1;
          pc_nxt    = pc_adv;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == WAIT);
  assign done = (state == DONE);

  sat_counter #(.W(CW)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .inc   (busy),
    .cnt   (cycle_cnt)
  );

  sat_counter #(.W(CW)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .inc   (commit),
    .cnt   (instr_cnt)
  );

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl (D=4, END_ADDR=12, MEM_LAT=2, CW=5): a per-PC program table drives the
// decoder inputs and an instruction-level model predicts every output each cycle.
module tb_core_run_ctrl;

  localparam int          END  = 12;
  localparam int          LAT  = 2;
  localparam int          CMAX = 31;
  localparam int          NPC  = 16;
  localparam logic [8:0]  HALT = 9'h1FF;

  logic       clk, reset, req;
  logic [3:0] start_addr, target, prog_ctr;
  logic [8:0] instr;
  logic       is_mem, branch_en, branch_taken;
  logic       commit, busy, done;
  logic [4:0] cycle_cnt, instr_cnt;

  core_run_ctrl #(.D(4), .END_ADDR(END), .MEM_LAT(LAT), .CW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .start_addr   (start_addr),
    .instr        (instr),
    .is_mem       (is_mem),
    .branch_en    (branch_en),
    .branch_taken (branch_taken),
    .target       (target),
    .prog_ctr     (prog_ctr),
    .commit       (commit),
    .busy         (busy),
    .done         (done),
    .cycle_cnt    (cycle_cnt),
    .instr_cnt    (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Program image indexed by PC.
  logic [8:0] p_instr [NPC];
  bit         p_mem   [NPC];
  bit         p_ben   [NPC];
  bit         p_btk   [NPC];
  int         p_tgt   [NPC];
  int         s_addr;

  // Model: phase 0 idle, 1 running, 2 finished; m_left = wait cycles still owed by a memory instruction.
  int m_pc, m_phase, m_left, m_cyc, m_ins;
  int n_pc, n_phase, n_left, n_cyc, n_ins;
  bit e_commit;

  function automatic logic [16:0] dut_vec();
    return {prog_ctr, busy, done, commit, cycle_cnt, instr_cnt};
  endfunction

  function automatic logic [16:0] exp_vec();
    return {4'(m_pc), m_phase == 1, m_phase == 2, e_commit, 5'(m_cyc), 5'(m_ins)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < NPC; i++) begin
      p_instr[i] = 9'h000; p_mem[i] = 0; p_ben[i] = 0; p_btk[i] = 0; p_tgt[i] = 0;
    end
  endtask

  // Present the instruction at the model PC, predict this cycle's commit and next model state.
  task automatic drive_cycle(input bit rq);
    req          = rq;
    start_addr   = 4'(s_addr);
    instr        = p_instr[m_pc];
    is_mem       = p_mem[m_pc];
    branch_en    = p_ben[m_pc];
    branch_taken = p_btk[m_pc];
    target       = 4'(p_tgt[m_pc]);
    n_pc = m_pc; n_phase = m_phase; n_left = m_left; n_cyc = m_cyc; n_ins = m_ins;
    e_commit = 0;
    if (m_phase == 1) begin
      n_cyc = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
      if (m_left == 0) begin
        if (m_pc == END || p_instr[m_pc] == HALT) n_phase = 2;
        else if (p_mem[m_pc] && LAT > 0)           n_left = LAT;
        else                                       e_commit = 1;
      end else begin
        n_left = m_left - 1;
        e_commit = (n_left == 0);
      end
      if (e_commit) begin
        n_ins = (m_ins < CMAX) ? m_ins + 1 : CMAX;
        n_pc  = (p_ben[m_pc] && p_btk[m_pc]) ? p_tgt[m_pc] : (m_pc + 1) % NPC;
      end
    end else if (rq) begin
      n_pc = s_addr; n_phase = 1; n_left = 0; n_cyc = 0; n_ins = 0;
    end
    #2;
  endtask

  task automatic finish_cycle();
    m_pc = n_pc; m_phase = n_phase; m_left = n_left; m_cyc = n_cyc; m_ins = n_ins;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pc = 0; m_phase = 0; m_left = 0; m_cyc = 0; m_ins = 0; e_commit = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b0);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      checks++;
      finish_cycle();
    end
  endtask

  task automatic test_straight_run();
    clear_prog(); s_addr = 0;
    for (int c = 0; c < 16; c++) begin
      drive_cycle(c == 0);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL straight c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      checks++;
      finish_cycle();
    end
    if (cycle_cnt !== 5'd13 || instr_cnt !== 5'd12 || done !== 1'b1) begin
      errors++; $display("FAIL straight_totals got %0d/%0d/%b exp 13/12/1", cycle_cnt, instr_cnt, done);
    end
    checks++;
  endtask

  task automatic test_wait_states();
    clear_prog(); s_addr = 0; p_mem[1] = 1;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(c == 0);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL wait c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      checks++;
      finish_cycle();
    end
    if (cycle_cnt !== 5'd15 || instr_cnt !== 5'd12) begin
      errors++; $display("FAIL wait_totals got %0d/%0d exp 15/12", cycle_cnt, instr_cnt);
    end
    checks++;
  endtask

  task automatic test_branch();
    for (int run = 0; run < 2; run++) begin
      clear_prog(); s_addr = 0;
      p_ben[2] = 1; p_btk[2] = (run == 0); p_tgt[2] = 10;
      for (int c = 0; c < 16; c++) begin
        drive_cycle(c == 0);
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL branch r%0d c%0d got %h exp %h", run, c, dut_vec(), exp_vec());
        end
        checks++;
        finish_cycle();
      end
      if (instr_cnt !== ((run == 0) ? 5'd5 : 5'd12) || prog_ctr !== 4'd12) begin
        errors++; $display("FAIL branch_totals r%0d got ins=%0d pc=%0d", run, instr_cnt, prog_ctr);
      end
      checks++;
    end
  endtask

  task automatic test_halt_priority();
    clear_prog(); s_addr = 0; p_instr[5] = HALT; p_mem[5] = 1;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(c == 0);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL halt c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      checks++;
      finish_cycle();
    end
    if (instr_cnt !== 5'd5 || prog_ctr !== 4'd5 || done !== 1'b1) begin
      errors++; $display("FAIL halt_totals got ins=%0d pc=%0d done=%b exp 5/5/1", instr_cnt, prog_ctr, done);
    end
    checks++;
  endtask

  task automatic test_wrap();
    clear_prog(); s_addr = 13;
    for (int c = 0; c < 19; c++) begin
      drive_cycle(c == 0);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL wrap c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      checks++;
      finish_cycle();
    end
    if (instr_cnt !== 5'd15 || cycle_cnt !== 5'd16) begin
      errors++; $display("FAIL wrap_totals got %0d/%0d exp 15/16", instr_cnt, cycle_cnt);
    end
    checks++;
    clear_prog(); s_addr = 2; p_ben[3] = 1; p_btk[3] = 1; p_tgt[3] = END;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(c == 0);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL br_end c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      checks++;
      finish_cycle();
    end
  endtask

  // Tight loop with req held high throughout: counters must saturate and the run must not restart.
  task automatic test_saturation();
    clear_prog(); s_addr = 0; p_ben[3] = 1; p_btk[3] = 1; p_tgt[3] = 0;
    for (int c = 0; c < 42; c++) begin
      drive_cycle(1'b1);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL sat c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      checks++;
      finish_cycle();
    end
    if (cycle_cnt !== 5'd31 || instr_cnt !== 5'd31 || busy !== 1'b1) begin
      errors++; $display("FAIL sat_totals got %0d/%0d busy=%b exp 31/31/1", cycle_cnt, instr_cnt, busy);
    end
    checks++;
  endtask

  task automatic test_control();
    apply_reset();
    // Run straight to DONE with req held: DONE must restart immediately.
    clear_prog(); s_addr = 4;
    for (int c = 0; c < 14; c++) begin
      drive_cycle(1'b1);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL req_hold c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      checks++;
      finish_cycle();
    end
    // Reset while the memory instruction at PC 5 is waiting.
    apply_reset();
    clear_prog(); s_addr = 4; p_mem[5] = 1;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(c == 0);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL pre_rst c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      checks++;
      finish_cycle();
    end
    apply_reset();
    drive_cycle(1'b0);
    if (dut_vec() !== exp_vec() || busy !== 1'b0 || commit !== 1'b0) begin
      errors++; $display("FAIL rst_in_wait got %h exp %h", dut_vec(), exp_vec());
    end
    checks++;
    finish_cycle();
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < NPC; i++) begin
        p_instr[i] = ($urandom_range(0, 11) == 0) ? HALT : 9'($urandom_range(0, 510));
        p_mem[i]   = ($urandom_range(0, 3) == 0);
        p_ben[i]   = ($urandom_range(0, 4) == 0);
        p_btk[i]   = $urandom_range(0, 1);
        p_tgt[i]   = $urandom_range(0, NPC - 1);
      end
      s_addr = $urandom_range(0, NPC - 1);
      for (int c = 0; c < 40; c++) begin
        drive_cycle((c == 0) || ($urandom_range(0, 7) == 0));
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL random p%0d c%0d got %h exp %h", p, c, dut_vec(), exp_vec());
        end
        checks++;
        finish_cycle();
      end
    end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; start_addr = '0; instr = '0; is_mem = 1'b0;
    branch_en = 1'b0; branch_taken = 1'b0; target = '0;
    s_addr = 0; e_commit = 0;
    m_pc = 0; m_phase = 0; m_left = 0; m_cyc = 0; m_ins = 0;
    clear_prog();
    test_reset();
    test_straight_run();
    test_wait_states();
    test_branch();
    test_halt_priority();
    test_wrap();
    test_saturation();
    test_control();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
